clint: RTL and testbench

Core-local interruptor for the Noname core. It is the source end of the machine interrupt lines that the write-back stage samples (`xint_msip`, `xint_mtip`, `xint_meip`). It holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` software-interrupt bit, all reachable over a Wishbone-classic slave port. It also synchronises the asynchronous external interrupt request into the core clock domain.

---
 rtl/clint.sv | 88 ++++++++
 tb/tb_clint.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// clint: core-local interruptor holding mtime/mtimecmp/msip behind a Wishbone-classic slave,
// driving the machine software/timer/external interrupt lines.
module clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    input  logic        ext_irq_i,
    output logic        xint_msip_o,
    output logic        xint_mtip_o,
    output logic        xint_meip_o
);
    localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);
    logic [63:0] mtime, mtimecmp;
    logic [15:0] presc;
    logic [1:0]  meip_sync;
    logic [31:0] rdata;
    logic        msip, mtip, req, hit, wr, tick;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val, input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? val[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Exact-word decode also rejects any misaligned offset.
    assign sel_msip    = wbs_addr_i == 16'h0000;
    assign sel_cmp_lo  = wbs_addr_i == 16'h4000;
    assign sel_cmp_hi  = wbs_addr_i == 16'h4004;
    assign sel_time_lo = wbs_addr_i == 16'hBFF8;
    assign sel_time_hi = wbs_addr_i == 16'hBFFC;
    assign hit  = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
    assign req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign wr   = req & hit & wbs_we_i;
    assign tick = presc == PRE_MAX;
    assign rdata = sel_msip   ? {31'b0, msip} :
                   sel_cmp_lo ? mtimecmp[31:0] :
                   sel_cmp_hi ? mtimecmp[63:32] :
                   sel_time_lo ? mtime[31:0] : mtime[63:32];

    assign xint_msip_o = msip;
    assign xint_mtip_o = mtip;
    assign xint_meip_o = meip_sync[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            mtip      <= 1'b0;
            presc     <= '0;
            meip_sync <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            presc     <= tick ? '0 : presc + 16'd1;
            meip_sync <= {meip_sync[0], ext_irq_i};
            mtip      <= mtime >= mtimecmp;
            wbs_ack_o <= req & hit;
            wbs_err_o <= req & ~hit;
            wbs_dat_o <= (req & hit & ~wbs_we_i) ? rdata : '0;
            if (wr & sel_msip & wbs_sel_i[0])
                msip <= wbs_dat_i[0];
            if (wr & sel_cmp_lo)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
            if (wr & sel_cmp_hi)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
            // A bus write to either half swallows a coincident tick.
            if (wr & sel_time_lo)
                mtime[31:0] <= merge(mtime[31:0], wbs_dat_i, wbs_sel_i);
            else if (wr & sel_time_hi)
                mtime[63:32] <= merge(mtime[63:32], wbs_dat_i, wbs_sel_i);
            else if (tick)
                mtime <= mtime + 64'd1;
        end
    end
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed checks of clint with TICK_DIV=1 and TICK_DIV=4 instances on a shared bus.
module tb_clint;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] addr;
    logic [31:0] dat_w, dat1, dat4, r1, r4;
    logic [3:0]  sel;
    logic        we, cyc, stb, ext_irq;
    logic        ack1, err1, msip1, mtip1, meip1;
    logic        ack4, err4, msip4, mtip4, meip4;
    logic        b_ack, b_err, found;
    logic [63:0] m_base;
    int          m_edge, ncyc, n_chk = 0, n_fail = 0, t_exp, c0, e;
    logic [15:0] e_addr [4] = '{16'h0004, 16'h4002, 16'h8000, 16'hBFF9};
    logic        e_we [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    clint #(.TICK_DIV(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(dat1), .wbs_ack_o(ack1),
        .wbs_err_o(err1), .ext_irq_i(ext_irq), .xint_msip_o(msip1), .xint_mtip_o(mtip1),
        .xint_meip_o(meip1)
    );

    clint #(.TICK_DIV(4)) u_div4 (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(dat4), .wbs_ack_o(ack4),
        .wbs_err_o(err4), .ext_irq_i(ext_irq), .xint_msip_o(msip4), .xint_mtip_o(mtip4),
        .xint_meip_o(meip4)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; mtime of the TICK_DIV=1 instance tracks this.
    always @(posedge clk or posedge rst)
        if (rst) ncyc <= 0;
        else ncyc <= ncyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        we = w; addr = a; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        b_ack = 1'b0; b_err = 1'b0;
        for (int i = 0; i < 8 && !(b_ack | b_err); i++) begin
            @(negedge clk);
            b_ack = ack1; b_err = err1; r1 = dat1; r4 = dat4;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!(b_ack | b_err)) check("bus_timeout", 0, 1);
    endtask

    function automatic logic [63:0] m_at(input int k);
        return m_base + 64'(k - m_edge);
    endfunction

    task automatic mt_write(input logic hi, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] pre;
        bus(1'b1, hi ? 16'hBFFC : 16'hBFF8, d, s);
        pre = m_at(ncyc - 1);
        for (int i = 0; i < 4; i++) if (s[i]) pre[(hi ? 32 : 0) + 8*i +: 8] = d[8*i +: 8];
        m_base = pre;
        m_edge = ncyc;
    endtask

    task automatic rd_time(input logic hi, input string tag);
        logic [63:0] exp;
        bus(1'b0, hi ? 16'hBFFC : 16'hBFF8, 32'h0, 4'hF);
        exp = m_at(ncyc - 1);
        check(tag, r1, hi ? exp[63:32] : exp[31:0]);
    endtask

    initial begin
        ext_irq = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; dat_w = '0; sel = '0;
        m_base = '0; m_edge = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack1, 0);
        check("rst_dat", dat1, 0);
        check("rst_mtip", mtip1, 0);
        rst = 1'b0;
        bus(1'b0, 16'h4000, 0, 4'hF); check("cmp_lo_rst", r1, 32'hFFFF_FFFF);
        bus(1'b0, 16'h4004, 0, 4'hF); check("cmp_hi_rst", r1, 32'hFFFF_FFFF);
        rd_time(1'b0, "mtime_lo_rst");
        check("mtime4_rst", r4, (ncyc - 1) / 4);

        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
        check("msip_ack", b_ack, 1);
        check("msip_on_ack", msip1, 1);
        bus(1'b0, 16'h0000, 0, 4'hF); check("msip_rd", r1, 32'h1);

        @(negedge clk) ext_irq = 1'b1;
        @(negedge clk) check("meip_early", meip1, 0);
        repeat (2) @(negedge clk);
        check("meip_rise", meip1, 1);
        ext_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("meip_fall", meip1, 0);
        ext_irq = 1'b1;
        repeat (3) @(negedge clk);
        check("meip_rise2", meip1, 1);

        addr = 16'h4000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_ack", ack1, 1);
        rst = 1'b1; #1;
        check("midrst_ack", ack1, 0);
        check("midrst_err", err1, 0);
        check("midrst_dat", dat1, 0);
        check("midrst_msip", msip1, 0);
        check("midrst_mtip", mtip1, 0);
        check("midrst_meip", meip1, 0);
        @(negedge clk) begin cyc = 1'b0; stb = 1'b0; ext_irq = 1'b0; end
        m_base = '0; m_edge = 0;
        @(negedge clk) rst = 1'b0;
        bus(1'b0, 16'h4000, 0, 4'hF); check("cmp_lo_rst2", r1, 32'hFFFF_FFFF);
        rd_time(1'b0, "mtime_lo_rst2");
        bus(1'b0, 16'h0000, 0, 4'hF); check("msip_rst2", r1, 0);

        bus(1'b1, 16'h4004, 0, 4'hF);
        bus(1'b1, 16'h4000, 32'h20, 4'hF);
        check("mtip_below", mtip1, 0);
        t_exp = m_edge + 32 - int'(m_base) + 1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = mtip1;
        end
        check("mtip_rise", found, 1);
        check("mtip_rise_cycle", ncyc, t_exp);
        bus(1'b1, 16'h4004, 32'h1, 4'hF);
        check("mtip_on_ack", mtip1, 1);
        @(negedge clk) check("mtip_fall", mtip1, 0);

        mt_write(1'b1, 32'hFFFF_FFFF, 4'hF);
        mt_write(1'b0, 32'hFFFF_FFFE, 4'hF);
        check("mtip_big", mtip1, 1);
        repeat (2) @(negedge clk);
        check("mtip_pre_wrap", mtip1, 1);
        @(negedge clk) check("mtip_post_wrap", mtip1, 0);
        rd_time(1'b0, "wrap_lo");
        rd_time(1'b1, "wrap_hi");
        mt_write(1'b0, 32'h1234_5600, 4'hF);
        mt_write(1'b0, 32'hFFFF_FFAB, 4'b0001);
        rd_time(1'b0, "byte_lo");
        rd_time(1'b1, "byte_hi");

        for (int i = 0; i < 4; i++) begin
            bus(e_we[i], e_addr[i], 32'hFFFF_FFFF, 4'hF);
            check("err_flag", b_err, 1);
            check("err_noack", b_ack, 0);
            check("err_dat", r1, 0);
            @(negedge clk) check("err_pulse", err1, 0);
        end
        bus(1'b0, 16'h4000, 0, 4'hF); check("err_cmp_lo", r1, 32'h20);
        bus(1'b0, 16'h4004, 0, 4'hF); check("err_cmp_hi", r1, 32'h1);
        bus(1'b0, 16'h0000, 0, 4'hF); check("err_msip", r1, 0);
        rd_time(1'b0, "err_time_lo");
        rd_time(1'b1, "err_time_hi");

        bus(1'b0, 16'h4000, 0, 4'hF);
        c0 = ncyc;
        bus(1'b0, 16'h4004, 0, 4'hF);
        check("b2b_gap", ncyc - c0, 2);
        check("b2b_data", r1, 32'h1);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_base = '0; m_edge = 0;
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 16'hBFF8, 0, 4'hF);
            check("div4_rd", r4, (ncyc - 1) / 4);
            repeat (i) @(negedge clk);
        end
        @(negedge clk);
        while (ncyc % 4 != 3) @(negedge clk);
        mt_write(1'b0, 32'h5, 4'hF);
        e = ncyc;
        bus(1'b0, 16'hBFF8, 0, 4'hF);
        check("div4_wr_wins", r4, 5);
        repeat (6) @(negedge clk);
        bus(1'b0, 16'hBFF8, 0, 4'hF);
        check("div4_after", r4, 5 + (ncyc - 1 - e) / 4);
        rd_time(1'b0, "div1_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
